seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
Parametrised multiplexed 7-segment display driver for NUM_DIGITS common-anode digits with active-low anodes and segments.
- Scans digits with a guard band of all-anodes-off between digits to suppress ghosting.
- Decodes each nibble in hex or BCD mode, with optional leading-zero blanking, per-digit enable and decimal points.
- Captures input data once per frame so a frame never shows a mix of old and new values.
- Sits between the datapath value registers and the board pins, replacing the fixed 4-digit BCD scan chain.

Parameters:
NUM_DIGITS, 4, number of digits scanned (legal 1..8)
BLANK_CYCLES, 16, guard cycles per slot with all anodes off (>=1)
ON_CYCLES, 25000, cycles per slot with the digit anode driven (>=1); default gives about 1 kHz per digit at 100 MHz

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
digits  in  4*NUM_DIGITS  nibble i = digit i; digit 0 is least significant (rightmost)
dp  in  NUM_DIGITS  decimal point request per digit, active high
digit_en  in  NUM_DIGITS  per-digit enable, active high
hex_mode  in  1  1 = hex decode, 0 = BCD decode
lz_blank  in  1  1 = blank leading zeros
anode  out  NUM_DIGITS  active-low digit select
seg  out  7  active-low segments {a,b,c,d,e,f,g}; seg[6]=a, seg[0]=g
dp_n  out  1  active-low decimal point
frame_start  out  1  one-cycle pulse when the snapshot is captured

Behaviour:
- All outputs are registered. reset low at a clk edge gives anode=all 1, seg=7'b1111111, dp_n=1, frame_start=0, state=LOAD, idx=0, cnt=0, snapshot=0.
- FSM states are LOAD, BLANK and ON.
  - LOAD (1 cycle): capture digits/dp/digit_en/hex_mode/lz_blank into the snapshot; frame_start=1; go to BLANK with idx=0.
  - BLANK (BLANK_CYCLES cycles): all anodes 1; seg/dp_n take the decode of snapshot digit idx.
  - ON (ON_CYCLES cycles): anode[idx]=0 if the digit is visible, otherwise all anodes 1. Then, if idx<NUM_DIGITS-1, idx+1 and go to BLANK; else go to LOAD.
- Frame length is exactly 1 + NUM_DIGITS*(BLANK_CYCLES+ON_CYCLES) cycles. Slot timing is identical whether a digit is visible or not, so brightness stays constant.
- Output timing: anode[idx] is low exactly for the ON_CYCLES clk periods of slot idx. seg/dp_n change only in the first BLANK cycle of a slot and are never glitched while any anode is low. During LOAD, seg=7'b1111111 and dp_n=1.
- Visible(i) = digit_en[i] AND NOT lz(i).
  - lz(i)=1 when lz_blank=1, i>0, and snapshot nibbles i..NUM_DIGITS-1 are all zero.
  - Digit 0 is never leading-zero blanked.
- Hex decode, 0..F: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100, 0001000 (A), 1100000 (b), 0110001 (C), 1000010 (d), 0110000 (E), 0111000 (F).
- BCD decode: 0..9 as hex; 10..15 show dash 7'b1111110.
- dp_n = ~dp_snapshot[idx] during BLANK/ON of slot idx. Forced to 1 if the digit is not visible.
- Input changes outside LOAD have no effect until the next LOAD.
- Reset mid-operation, in any state: the next cycle gives the reset values. A new frame starts with LOAD on the first edge after reset returns high.
- Counter widths use $clog2(max(BLANK_CYCLES,ON_CYCLES)) and $clog2(NUM_DIGITS). No wrap beyond terminal counts.
- Illegal parameter values are caught by elaboration-time assertions.

Decomposition:
- Package seg7_pkg: FSM state enum (LOAD, BLANK, ON), SEG_OFF and SEG_DASH constants, 16-entry hex segment table.
- Sub-module seg7_decoder (combinational): nibble, hex_mode → seg pattern.
- seg_scan_driver holds the snapshot, FSM, counters and output registers.

Test Plan:
1. Reset check, run with NUM_DIGITS=4, BLANK_CYCLES=2, ON_CYCLES=4: hold reset=0 for 3 cycles mid-frame → anode=4'b1111, seg=7'b1111111, dp_n=1, frame_start=0. Release → frame_start high on the first cycle, then slot 0 starts.
2. Scan order and timing: digits=16'h1234, digit_en=4'hF, hex_mode=0, lz_blank=0.
   - frame_start period is 25 cycles.
   - Anode sequence is 1110 (seg 1001100), 1101 (0000110), 1011 (0010010), 0111 (1001111), each low exactly 4 cycles, preceded by 2 cycles of 1111.
3. Decode modes: digits=16'hABCD with hex_mode=1 → per-digit seg 1000010, 0110001, 1100000, 0001000. Same digits with hex_mode=0 → 1111110 on all four.
4. Leading-zero blanking with lz_blank=1:
   - digits=16'h0050 → digits 3 and 2 anodes stay 1111 in their ON windows; digit 1 shows 0100100; digit 0 shows 0000001.
   - digits=16'h0000 → only digit 0 lit, showing 0000001.
5. Enables and decimal point: digit_en=4'b1011, dp=4'b0010 → slot 2 anodes stay 1111 for the full 6 cycles. dp_n=0 only during slot 1, and frame length is unchanged at 25 cycles.
6. Snapshot tearing: change digits from 16'h1111 to 16'h2222 during slot 1 ON → rest of the frame still shows 1001111. The next frame, after frame_start, shows 0010010 on all digits.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment scan driver:
// scan FSM states, fixed segment patterns and the hex glyph table.
// Segment patterns are active-low {a,b,c,d,e,f,g}, bit 6 = a, bit 0 = g.
package seg7_pkg;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_BLANK = 2'd1,
        S_ON    = 2'd2
    } state_t;

    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b1111110;

    localparam logic [6:0] SEG_HEX [16] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

endpackage

// File: rtl/seg7_decoder.sv
// Combinational nibble-to-segment decode. In BCD mode the non-decimal
// codes 10..15 render as a dash so bad data is visible on the display.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_hex_mode,
    output logic [6:0] o_seg
);

    // Table lookup, overridden by the dash for out-of-range BCD codes.
    always_comb begin
        o_seg = SEG_HEX[i_nibble];
        if (!i_hex_mode && (i_nibble > 4'd9)) begin
            o_seg = SEG_DASH;
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode 7-segment scan driver with per-frame snapshot,
// guard band between digits, leading-zero blanking and decimal points.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_LOAD  | one cycle: capture inputs into the snapshot, pulse frame_start
// S_BLANK | BLANK_CYCLES: all anodes off, seg/dp_n settle for digit idx
// S_ON    | ON_CYCLES: anode idx driven if the digit is visible
//
// The FSM state names the action taken at the next clock edge, so the
// registered outputs for a state appear during the cycle after that edge.
// Every slot takes the same time whether its digit is lit or not, which
// keeps the per-digit brightness independent of the displayed value.
module seg_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int BLANK_CYCLES = 16,
    parameter int ON_CYCLES    = 25000
)
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    hex_mode,
    input  logic                    lz_blank,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic                    frame_start
);

    localparam int MAX_CYC = (BLANK_CYCLES > ON_CYCLES) ? BLANK_CYCLES : ON_CYCLES;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    if ((NUM_DIGITS < 1) || (NUM_DIGITS > 8)) begin : g_bad_num_digits
        $error("seg_scan_driver: NUM_DIGITS must be 1..8");
    end
    if (BLANK_CYCLES < 1) begin : g_bad_blank_cycles
        $error("seg_scan_driver: BLANK_CYCLES must be >= 1");
    end
    if (ON_CYCLES < 1) begin : g_bad_on_cycles
        $error("seg_scan_driver: ON_CYCLES must be >= 1");
    end

    state_t                  r_state;
    logic [IW-1:0]           r_idx;
    logic [CW-1:0]           r_cnt;

    logic [4*NUM_DIGITS-1:0] r_snap_digits;
    logic [NUM_DIGITS-1:0]   r_snap_dp;
    logic [NUM_DIGITS-1:0]   r_snap_en;
    logic                    r_snap_hex;
    logic                    r_snap_lz;

    logic [NUM_DIGITS-1:0]   r_anode;
    logic [6:0]              r_seg;
    logic                    r_dp_n;
    logic                    r_frame_start;

    logic [NUM_DIGITS-1:0]   w_visible;
    logic [NUM_DIGITS-1:0]   w_sel;
    logic [3:0]              w_nibble;
    logic [6:0]              w_seg_dec;

    assign w_nibble = r_snap_digits[4*r_idx +: 4];
    assign w_sel    = NUM_DIGITS'(1) << r_idx;

    seg7_decoder u_decoder (
        .i_nibble   (w_nibble),
        .i_hex_mode (r_snap_hex),
        .o_seg      (w_seg_dec)
    );

    // Visibility per digit: enabled and not part of a run of leading zeros
    // (scanning from the most significant digit down; digit 0 always kept).
    always_comb begin : p_visible
        logic v_upper_zero;
        v_upper_zero = 1'b1;
        w_visible    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            v_upper_zero = v_upper_zero && (r_snap_digits[4*i +: 4] == 4'd0);
            w_visible[i] = r_snap_en[i] && !(r_snap_lz && (i > 0) && v_upper_zero);
        end
    end

    // Scan FSM, slot down-counter, snapshot capture and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_LOAD;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_snap_digits <= '0;
            r_snap_dp     <= '0;
            r_snap_en     <= '0;
            r_snap_hex    <= 1'b0;
            r_snap_lz     <= 1'b0;
            r_anode       <= '1;
            r_seg         <= SEG_OFF;
            r_dp_n        <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    r_snap_digits <= digits;
                    r_snap_dp     <= dp;
                    r_snap_en     <= digit_en;
                    r_snap_hex    <= hex_mode;
                    r_snap_lz     <= lz_blank;
                    r_frame_start <= 1'b1;
                    r_anode       <= '1;
                    r_seg         <= SEG_OFF;
                    r_dp_n        <= 1'b1;
                    r_idx         <= '0;
                    r_cnt         <= BLANK_LAST;
                    r_state       <= S_BLANK;
                end
                S_BLANK: begin
                    r_anode <= '1;
                    r_seg   <= w_seg_dec;
                    r_dp_n  <= ~(r_snap_dp[r_idx] & w_visible[r_idx]);
                    if (r_cnt == '0) begin
                        r_cnt   <= ON_LAST;
                        r_state <= S_ON;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_ON: begin
                    r_anode <= w_visible[r_idx] ? ~w_sel : '1;
                    if (r_cnt == '0) begin
                        if (r_idx == IDX_LAST) begin
                            r_state <= S_LOAD;
                        end else begin
                            r_idx   <= r_idx + IW'(1);
                            r_cnt   <= BLANK_LAST;
                            r_state <= S_BLANK;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

    assign anode       = r_anode;
    assign seg         = r_seg;
    assign dp_n        = r_dp_n;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver (4 digits, 2 guard cycles, 4 on cycles).
// A frame-position model predicts every output each cycle; directed frames
// pin the model against hand-written glyph/anode values; a random phase
// stirs inputs and resets.
module tb_seg_scan_driver;

    localparam int N     = 4;
    localparam int B     = 2;
    localparam int O     = 4;
    localparam int SLOT  = B + O;
    localparam int FRAME = 1 + N * SLOT;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  digit_en;
    logic        hex_mode;
    logic        lz_blank;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        dp_n;
    logic        frame_start;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seg_scan_driver #(
        .NUM_DIGITS   (N),
        .BLANK_CYCLES (B),
        .ON_CYCLES    (O)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .digits      (digits),
        .dp          (dp),
        .digit_en    (digit_en),
        .hex_mode    (hex_mode),
        .lz_blank    (lz_blank),
        .anode       (anode),
        .seg         (seg),
        .dp_n        (dp_n),
        .frame_start (frame_start)
    );

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'b0000001;
            4'h1: glyph = 7'b1001111;
            4'h2: glyph = 7'b0010010;
            4'h3: glyph = 7'b0000110;
            4'h4: glyph = 7'b1001100;
            4'h5: glyph = 7'b0100100;
            4'h6: glyph = 7'b0100000;
            4'h7: glyph = 7'b0001111;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0000100;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b1100000;
            4'hC: glyph = 7'b0110001;
            4'hD: glyph = 7'b1000010;
            4'hE: glyph = 7'b0110000;
            default: glyph = 7'b0111000;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: position within the frame decides everything.
    bit          mvalid = 1'b0;
    int          ph;
    logic [15:0] s_dig;
    logic [3:0]  s_dp, s_en;
    logic        s_hex, s_lz;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dpn, e_fs;

    always @(posedge clk) begin : model
        int k, slot, w;
        logic [3:0] nib;
        logic vis;
        if (!reset) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dpn = 1'b1; e_fs = 1'b0;
            ph = 0; mvalid = 1'b1;
        end else if (mvalid) begin
            if (ph == 0) begin
                s_dig = digits; s_dp = dp; s_en = digit_en;
                s_hex = hex_mode; s_lz = lz_blank;
                e_fs = 1'b1; e_an = 4'hF; e_seg = 7'h7F; e_dpn = 1'b1;
            end else begin
                k    = ph - 1;
                slot = k / SLOT;
                w    = k % SLOT;
                nib  = s_dig[slot*4 +: 4];
                vis  = s_en[slot] && !(s_lz && slot > 0 && (s_dig >> (4*slot)) == 16'h0);
                e_fs  = 1'b0;
                e_seg = (s_hex || nib < 4'd10) ? glyph(nib) : 7'b1111110;
                e_dpn = !(s_dp[slot] && vis);
                e_an  = 4'hF;
                if (w >= B && vis) e_an[slot] = 1'b0;
            end
            ph = (ph + 1) % FRAME;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (mvalid) begin
            chk("model_anode", 32'(anode), 32'(e_an));
            chk("model_seg", 32'(seg), 32'(e_seg));
            chk("model_dp_n", 32'(dp_n), 32'(e_dpn));
            chk("model_frame_start", 32'(frame_start), 32'(e_fs));
        end
    end

    task automatic wait_fs();
        int n;
        n = 0;
        @(negedge clk);
        while (frame_start !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wait_frame_start", 32'(frame_start), 32'h1);
    endtask

    // Called at the negedge where frame_start is seen; walks one frame and
    // checks the first ON cycle of every slot, then the next frame_start.
    task automatic check_frame(input string tag, input logic [15:0] ex_an,
                               input logic [27:0] ex_seg, input logic [3:0] ex_dpn,
                               input int chg_pos, input logic [15:0] chg_val);
        int s;
        chk({tag, "_fs"}, 32'(frame_start), 32'h1);
        for (int p = 1; p < FRAME; p++) begin
            @(negedge clk);
            if (p == chg_pos) digits = chg_val;
            if ((p - 1) % SLOT == B) begin
                s = (p - 1) / SLOT;
                chk({tag, "_anode"}, 32'(anode), 32'(ex_an[s*4 +: 4]));
                if (ex_an[s*4 +: 4] != 4'hF)
                    chk({tag, "_seg"}, 32'(seg), 32'(ex_seg[s*7 +: 7]));
                chk({tag, "_dp_n"}, 32'(dp_n), 32'(ex_dpn[s]));
            end
        end
        @(negedge clk);
        chk({tag, "_period"}, 32'(frame_start), 32'h1);
    endtask

    function automatic logic [15:0] rnd_digits();
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < 4; i++)
            if ($urandom_range(0, 1) == 1) v[i*4 +: 4] = 4'($urandom);
        return v;
    endfunction

    initial begin
        #1_000_000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        reset = 1'b0; digits = 16'h0; dp = 4'h0; digit_en = 4'hF;
        hex_mode = 1'b0; lz_blank = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_anode", 32'(anode), 32'hF);
        chk("reset_seg", 32'(seg), 32'h7F);
        chk("reset_fs", 32'(frame_start), 32'h0);

        // Scan order and timing.
        reset = 1'b1;
        digits = 16'h1234;
        wait_fs();
        check_frame("scan", 16'h7BDE,
                    {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 4'hF, -1, 16'h0);

        // Reset mid-frame, then the frame restarts from LOAD.
        repeat (10) @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("midreset_anode", 32'(anode), 32'hF);
            chk("midreset_seg", 32'(seg), 32'h7F);
            chk("midreset_dp_n", 32'(dp_n), 32'h1);
            chk("midreset_fs", 32'(frame_start), 32'h0);
        end
        reset = 1'b1;
        @(negedge clk);
        check_frame("post_reset", 16'h7BDE,
                    {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 4'hF, -1, 16'h0);

        // Hex and BCD decode.
        digits = 16'hABCD; hex_mode = 1'b1;
        wait_fs();
        check_frame("hex", 16'h7BDE,
                    {7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010}, 4'hF, -1, 16'h0);
        hex_mode = 1'b0;
        wait_fs();
        check_frame("bcd", 16'h7BDE, {4{7'b1111110}}, 4'hF, -1, 16'h0);

        // Leading-zero blanking.
        lz_blank = 1'b1; digits = 16'h0050;
        wait_fs();
        check_frame("lz0050", 16'hFFDE,
                    {7'b0000001, 7'b0000001, 7'b0100100, 7'b0000001}, 4'hF, -1, 16'h0);
        digits = 16'h0000;
        wait_fs();
        check_frame("lz0000", 16'hFFFE, {4{7'b0000001}}, 4'hF, -1, 16'h0);

        // Enables and decimal point.
        lz_blank = 1'b0; digits = 16'h1234; digit_en = 4'b1011; dp = 4'b0010;
        wait_fs();
        check_frame("en_dp", 16'h7FDE,
                    {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 4'b1101, -1, 16'h0);

        // Snapshot tearing: change mid-frame, visible only next frame.
        digit_en = 4'hF; dp = 4'h0; digits = 16'h1111;
        wait_fs();
        check_frame("tear_old", 16'h7BDE, {4{7'b1001111}}, 4'hF, 10, 16'h2222);
        check_frame("tear_new", 16'h7BDE, {4{7'b0010010}}, 4'hF, -1, 16'h0);

        // Random stimulus and occasional resets, checked by the model.
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                reset = 1'b1;
            end
            if ($urandom_range(0, 7) == 0) begin
                digits   = rnd_digits();
                dp       = 4'($urandom);
                digit_en = 4'($urandom);
                hex_mode = 1'($urandom);
                lz_blank = 1'($urandom);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
